// File: rtl/spi_periph_if.sv
// CPU-side bus of the SPI master peripheral.
//
// Bus protocol: there is no valid/ready pair. cs is a single-cycle strobe.
// A write happens on every clk edge where cs & we, and it is always
// accepted. A read happens on every clk edge where cs & !we; dout holds
// reg[rs] from the following cycle. irq is a level, valid whenever sampled.
interface spi_periph_if;
  logic       cs;
  logic       we;
  logic [1:0] rs;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  modport master (output cs, we, rs, din, input dout, irq);
  modport slave  (input cs, we, rs, din, output dout, irq);
endinterface

// File: rtl/spi_periph.sv
// Byte-wide SPI master (mode 0, MSB first) on the 6502 bus.
// Registers: 0 DATA, 1 STAT {BUSY, DONE, 5'b0, IE}, 2 DIV, 3 SS.
// The SCK half-period is DIV+1 clk cycles. A transfer takes 16*(DIV+1) cycles.
module spi_periph #(
  parameter logic [7:0] DIV_INIT = 8'd3
) (
  input  logic         clk,
  input  logic         reset,      // asynchronous, active low
  spi_periph_if.slave  bus,
  output logic         spi_sck,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic         spi_ss_n,
  output logic [1:0]   fsm_state   // debug view: 0 IDLE, 1 LOW, 2 HIGH
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] div_q;     // software-visible divider
  logic [7:0] div_w;     // working copy, latched at transfer start
  logic [7:0] cnt_q;     // half-period counter
  logic [2:0] bit_q;     // bits completed in this transfer
  logic [7:0] sh_q;      // shift register: tx out of the top, rx into the bottom
  logic [7:0] rx_q;      // last received byte
  logic       mosi_q;
  logic       done_q;
  logic       ie_q;
  logic       ss_q;
  logic [7:0] dout_q;

  logic       wr, rd;
  logic       start;
  logic       half_end;
  logic       last_bit;
  logic       done_set;
  logic       done_clr;
  logic       busy;
  logic       sck_c;

  assign wr       = bus.cs & bus.we;
  assign rd       = bus.cs & ~bus.we;
  // A DATA write while busy is dropped here, so it never disturbs a transfer.
  assign start    = wr && (bus.rs == 2'd0) && (state_q == ST_IDLE);
  assign half_end = (cnt_q == div_w);
  assign last_bit = (bit_q == 3'd7);
  assign done_set = (state_q == ST_HIGH) && half_end && last_bit;
  assign done_clr = (rd && (bus.rs == 2'd0)) ||
                    (wr && (bus.rs == 2'd1) && bus.din[6]);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: each SCK phase lasts div_w+1 cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)    state_d = ST_LOW;
      ST_LOW:  if (half_end) state_d = ST_HIGH;
      ST_HIGH: if (half_end) state_d = last_bit ? ST_IDLE : ST_LOW;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Output decode: SCK and BUSY come straight from the state register.
  always_comb begin
    sck_c = 1'b0;
    busy  = 1'b0;
    case (state_q)
      ST_LOW:  busy = 1'b1;
      ST_HIGH: begin
        busy  = 1'b1;
        sck_c = 1'b1;
      end
      default: begin
        sck_c = 1'b0;
        busy  = 1'b0;
      end
    endcase
  end

  // Shift datapath. MISO enters the bottom on the edge that raises SCK.
  // The next MSB then sits in sh_q[7] and goes onto MOSI when SCK falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q   <= 8'h00;
      div_w  <= 8'h00;
      cnt_q  <= 8'h00;
      bit_q  <= 3'd0;
      mosi_q <= 1'b0;
      rx_q   <= 8'h00;
    end else if (start) begin
      sh_q   <= bus.din;
      mosi_q <= bus.din[7];
      div_w  <= div_q;
      cnt_q  <= 8'h00;
      bit_q  <= 3'd0;
    end else if (state_q == ST_LOW) begin
      if (half_end) begin
        cnt_q <= 8'h00;
        sh_q  <= {sh_q[6:0], spi_miso};
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end else if (state_q == ST_HIGH) begin
      if (half_end) begin
        cnt_q <= 8'h00;
        bit_q <= bit_q + 3'd1;
        if (last_bit) rx_q   <= sh_q;
        else          mosi_q <= sh_q[7];
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // Software registers. When DONE is set and cleared on the same edge, the set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= DIV_INIT;
      ie_q   <= 1'b0;
      ss_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (wr && (bus.rs == 2'd1)) ie_q  <= bus.din[0];
      if (wr && (bus.rs == 2'd2)) div_q <= bus.din;
      if (wr && (bus.rs == 2'd3)) ss_q  <= bus.din[0];
      if (done_set)      done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;
    end
  end

  // Registered read mux. Writes never touch dout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= 8'h00;
    end else if (rd) begin
      case (bus.rs)
        2'd0:    dout_q <= rx_q;
        2'd1:    dout_q <= {busy, done_q, 5'b00000, ie_q};
        2'd2:    dout_q <= div_q;
        default: dout_q <= {7'b0000000, ss_q};
      endcase
    end
  end

  assign spi_sck   = sck_c;
  assign spi_mosi  = mosi_q;
  assign spi_ss_n  = ~ss_q;
  assign bus.dout  = dout_q;
  assign bus.irq   = done_q & ie_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_spi_periph.sv
// Directed and randomized bench for spi_periph. The reference model works
// at the byte level. MOSI must carry the tx byte MSB first, and the rx byte
// must equal the byte the slave model shifts out. Each SCK phase must last
// DIV+1 cycles, and a transfer must last 16*(DIV+1) cycles.
module tb_spi_periph;

  localparam logic [1:0] ST_IDLE = 2'd0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sck, mosi, miso, ss_n;
  logic [1:0] st;

  spi_periph_if bus ();

  spi_periph #(.DIV_INIT(8'd3)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .spi_sck   (sck),
    .spi_mosi  (mosi),
    .spi_miso  (miso),
    .spi_ss_n  (ss_n),
    .fsm_state (st)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [0:0] exp_q[$];
  logic [0:0] mosi_q[$];
  int         low_q[$];
  int         high_q[$];
  int         low_run = 0, high_run = 0, rise_cnt = 0;
  logic       sck_prev = 1'b0;
  logic [7:0] slv_byte = 8'h00;
  time        start_t;

  // Pin monitor and slave model. Sampling happens on the falling clk edge.
  // The slave shows bit 7-k after k SCK rises.
  always @(negedge clk) begin
    int idx;
    if (sck && !sck_prev) begin
      low_q.push_back(low_run);
      low_run = 0;
      mosi_q.push_back(mosi);
      rise_cnt++;
    end
    if (!sck && sck_prev) begin
      high_q.push_back(high_run);
      high_run = 0;
    end
    if (sck) high_run++;
    else if (st != ST_IDLE) low_run++;
    sck_prev = sck;
    idx = (rise_cnt > 7) ? 0 : 7 - rise_cnt;
    miso = slv_byte[idx];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.rs = a; bus.din = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b0; bus.rs = a;
    @(negedge clk);
    bus.cs = 1'b0;
    d = bus.dout;
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] sb, input string tag);
    slv_byte = sb;
    exp_q.delete(); mosi_q.delete(); low_q.delete(); high_q.delete();
    low_run = 0; high_run = 0; rise_cnt = 0;
    for (int i = 7; i >= 0; i--) exp_q.push_back(tx[i]);
    bus_write(2'd0, tx);
    start_t = $time;
    chk({tag, "_busy_at_start"}, st != ST_IDLE, 1);
    chk({tag, "_mosi_at_start"}, mosi, tx[7]);
  endtask

  task automatic finish_xfer(input int div, input bit exp_irq, input string tag);
    int n = 0;
    int bad = 0;
    logic [7:0] eb, ob;
    while (st != ST_IDLE && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, st == ST_IDLE, 1);
    chk({tag, "_cycles"}, int'(($time - start_t) / 10), 16 * (div + 1));
    chk({tag, "_irq_with_done"}, bus.irq, exp_irq);
    chk({tag, "_sck_idle"}, sck, 0);
    @(negedge clk);
    chk({tag, "_pulses"}, rise_cnt, 8);
    eb = 8'h00; ob = 8'hxx;
    for (int i = 7; i >= 0; i--) begin
      eb[i] = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      ob[i] = (mosi_q.size() > 0) ? mosi_q.pop_front() : 1'bx;
    end
    chk({tag, "_mosi_bits"}, ob, eb);
    if (low_q.size() != 8 || high_q.size() != 8) bad++;
    foreach (low_q[i])  if (low_q[i]  != div + 1) bad++;
    foreach (high_q[i]) if (high_q[i] != div + 1) bad++;
    chk({tag, "_phase_len"}, bad, 0);
  endtask

  initial begin
    logic [7:0] d, tx, sb;
    int div, n;

    bus.cs = 1'b0; bus.we = 1'b0; bus.rs = 2'd0; bus.din = 8'h00;
    miso = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset state.
    chk("rst_ss_n", ss_n, 1);
    chk("rst_sck", sck, 0);
    chk("rst_irq", bus.irq, 0);
    bus_read(2'd0, d); chk("rst_data", d, 8'h00);
    bus_read(2'd1, d); chk("rst_stat", d, 8'h00);
    bus_read(2'd2, d); chk("rst_div", d, 8'h03);
    bus_read(2'd3, d); chk("rst_ss", d, 8'h00);

    // DIV=0, SS=1, A5 out and 3C in.
    bus_write(2'd2, 8'h00);
    bus_write(2'd3, 8'h01);
    chk("ss_n_low", ss_n, 0);
    bus_read(2'd3, d); chk("ss_read", d, 8'h01);
    start_xfer(8'hA5, 8'h3C, "a5");
    finish_xfer(0, 1'b0, "a5");
    bus_read(2'd1, d); chk("a5_stat_done", d, 8'h40);
    bus_read(2'd0, d); chk("a5_rx", d, 8'h3C);
    bus_read(2'd1, d); chk("a5_done_cleared", d, 8'h00);

    // DIV=2, IE=1, FF out, MISO held low.
    bus_write(2'd2, 8'h02);
    bus_write(2'd1, 8'h01);
    start_xfer(8'hFF, 8'h00, "ff");
    finish_xfer(2, 1'b1, "ff");
    bus_read(2'd1, d); chk("ff_stat", d, 8'h41);
    bus_write(2'd1, 8'h41);
    chk("ff_irq_dropped", bus.irq, 0);
    bus_read(2'd1, d); chk("ff_ie_kept", d, 8'h01);
    bus_read(2'd0, d); chk("ff_rx", d, 8'h00);
    bus_write(2'd1, 8'h00);

    // DATA write during a transfer is ignored.
    sb = 8'($urandom_range(0, 255));
    start_xfer(8'h81, sb, "mid");
    repeat (20) @(negedge clk);
    bus_write(2'd0, 8'h12);
    finish_xfer(2, 1'b0, "mid");
    repeat (40) @(negedge clk);
    chk("mid_no_second_xfer", rise_cnt, 8);
    chk("mid_idle", st == ST_IDLE, 1);
    bus_read(2'd0, d); chk("mid_rx", d, sb);

    // DIV write during a transfer only affects the next one.
    bus_write(2'd2, 8'h01);
    start_xfer(8'h5A, 8'hC3, "div1");
    repeat (5) @(negedge clk);
    bus_write(2'd2, 8'h07);
    finish_xfer(1, 1'b0, "div1");
    bus_read(2'd2, d); chk("div_readback", d, 8'h07);
    start_xfer(8'h3C, 8'h96, "div7");
    finish_xfer(7, 1'b0, "div7");
    bus_read(2'd0, d); chk("div7_rx", d, 8'h96);

    // Randomized transfers against the byte-level model.
    for (int k = 0; k < 4; k++) begin
      div = $urandom_range(0, 3);
      tx  = 8'($urandom_range(0, 255));
      sb  = 8'($urandom_range(0, 255));
      bus_write(2'd2, 8'(div));
      start_xfer(tx, sb, "rnd");
      finish_xfer(div, 1'b0, "rnd");
      bus_read(2'd0, d); chk("rnd_rx", d, sb);
    end

    // Asynchronous reset in the middle of bit 4.
    bus_write(2'd3, 8'h01);
    bus_write(2'd1, 8'h01);
    start_xfer(8'hC7, 8'h5E, "abort");
    n = 0;
    while (rise_cnt < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_bit4", rise_cnt >= 4, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_sck", sck, 0);
    chk("abort_idle", st == ST_IDLE, 1);
    chk("abort_ss_n", ss_n, 1);
    chk("abort_irq", bus.irq, 0);
    @(negedge clk);
    reset = 1'b1;
    bus_read(2'd1, d); chk("abort_stat", d, 8'h00);
    bus_read(2'd2, d); chk("abort_div_init", d, 8'h03);
    bus_read(2'd0, d); chk("abort_rx_reset", d, 8'h00);
    start_xfer(8'h69, 8'hB4, "post");
    finish_xfer(3, 1'b0, "post");
    bus_read(2'd0, d); chk("post_rx", d, 8'hB4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_periph.md
# spi_periph

Byte-wide SPI master peripheral for the 6502 test SoC, a bus slave beside the ACIA. It is decoded at page 30-3f in the top level, and its registered read data feeds the CPU data-in mux. The CPU writes a byte and the block shifts it out in SPI mode 0, MSB first, while capturing the MISO byte. Completion is reported through a status flag and an optional level IRQ.

## Interface
- DIV_INIT, 8'd3, reset value of the clock-divider register.
- clk  in  1  system/CPU clock.
- reset  in  1  asynchronous, active-low reset.
- cs  in  1  chip select (page decode).
- we  in  1  write enable; a write occurs on any clk edge with cs & we.
- rs  in  2  register select (CPU_AB[1:0]).
- din  in  8  CPU write data.
- dout  out  8  registered read data.
- irq  out  1  interrupt request, active high, level.
- spi_sck  out  1  SPI clock, idle low.
- spi_mosi  out  1  SPI data out.
- spi_miso  in  1  SPI data in; synchronous to clk.
- spi_ss_n  out  1  slave select, active low, software controlled.

## Operation
- Registers, selected by rs:
  - 0 DATA. A write starts a transfer if not busy. A read returns the last received byte and clears DONE.
  - 1 STAT. Read value is {BUSY, DONE, 5'b0, IE}. A write sets IE = din[0]; din[6]=1 clears DONE.
  - 2 DIV. Read/write 8-bit divider. The SCK half-period is DIV+1 clk cycles.
  - 3 SS. Bit0 is SS, and spi_ss_n = ~SS. It reads back {7'b0, SS}.
- Reset values: DIV=DIV_INIT, IE=0, DONE=0, SS=0, rx byte=0, dout=0, spi_sck=0, spi_mosi=0, spi_ss_n=1, irq=0, FSM=IDLE.
- FSM states: IDLE, LOW, HIGH.
  - IDLE → LOW on a DATA write. The block loads the shift register with din, drives spi_mosi=din[7], latches DIV into a working divider, clears the half-period counter and the bit count, and sets BUSY.
  - LOW holds spi_sck=0 for DIV+1 cycles, then goes to HIGH with spi_sck=1. On entry to HIGH, spi_miso is sampled into the shift register LSB.
  - HIGH holds spi_sck=1 for DIV+1 cycles, then increments the bit count.
    - If the count was not yet 7: shift left, drive the next MSB on spi_mosi, set spi_sck=0, go to LOW.
    - After the 8th bit: spi_sck=0, rx byte ← shift register, BUSY=0, DONE=1, go to IDLE.
- spi_mosi holds its last value in IDLE.
- irq = DONE & IE. It is generated from registered state only, with no combinational path from bus inputs.
- A DATA write while BUSY is ignored and the transfer continues undisturbed.
- A DIV write while BUSY takes effect at the next transfer; the working copy is latched at start.
- The SS register is independent of the FSM. Software brackets multi-byte frames with it, and writing it mid-transfer changes spi_ss_n immediately with no other effect.
- DONE set vs clear on the same edge (completion coincident with a DATA read or a STAT clear): set wins. That read returns the previous rx byte.
- Reset asserted mid-transfer aborts it; all state returns to reset values asynchronously.
- Writes never modify dout.

## Timing
- Reads: dout updates at the clk edge where cs & !we, with dout ← reg[rs]. The data is valid one cycle after the address, matching the registered mux select in the top level.
- A read while cs=0 leaves dout unchanged.
- Bus write sampled at edge N:
  - BUSY=1 and spi_mosi=bit7 from N+1.
  - First spi_sck rise at N+1+(DIV+1).
  - Each half-period is DIV+1 cycles.
  - Final spi_sck fall, BUSY=0, DONE=1 and irq (if IE) all at N+1+16·(DIV+1).
- Full transfer occupies 16·(DIV+1) cycles; the minimum (DIV=0) is 16 cycles.
- The earliest next transfer is a DATA write sampled on the edge where BUSY reads 0.
- MISO is sampled on the clk edge that raises spi_sck. MOSI changes on the edge that lowers spi_sck, which is mode 0.

## Test plan
- Reset with DIV_INIT=3 → reads of rs=0..3 return 00, 00, 03, 00; spi_ss_n=1, spi_sck=0, irq=0.
- DIV=0, SS=1, write A5 with the slave returning 3C → MOSI bits 1,0,1,0,0,1,0,1 on rising edges and 8 SCK pulses. BUSY falls exactly 16 cycles after the write; DATA reads 3C; DONE clears after that read.
- DIV=2, IE=1, write FF with miso=0 → SCK high and low phases each 3 cycles, total 48 cycles. irq rises with DONE; writing STAT=41 drops irq while keeping IE=1.
- DATA write of 12 at mid-transfer of 81 → shift continues with 81 bits only; no second transfer.
- DIV write 07 during a DIV=1 transfer → current transfer uses a 2-cycle half-period; the next uses 8.
- reset low at bit 4 → spi_sck=0, BUSY=0, DONE=0, spi_ss_n=1 immediately, with no clk edge required; a subsequent transfer with DIV restored to DIV_INIT completes normally.
